fb_rect_writer: RTL

- Write-side companion to the LCD block ROMs: streams RGB565 pixels into a rectangular window of a 16-bit frame-buffer RAM.
- Takes a rectangle command (x0, y0, w, h) and a valid/ready pixel stream, and produces the RAM write strobe, address and data in raster order.
- Sits between sprite/game logic and the dual-port frame buffer that the LCD scan-out reads.

---
 rtl/fb_rect_writer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: streams RGB565 pixels from a valid/ready source into a
// rectangular window of a 16-bit frame-buffer RAM, in raster order.
// One pixel per cycle. There is one cycle of latency from accept to the RAM write.

module fb_rect_writer #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16,
    parameter int FB_WIDTH   = 480,
    parameter int FB_HEIGHT  = 272,
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [X_WIDTH-1:0]    x0,
    input  logic [Y_WIDTH-1:0]    y0,
    input  logic [X_WIDTH-1:0]    w,
    input  logic [Y_WIDTH-1:0]    h,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Screen limits at one bit wider than the operands, so the bounds sums cannot wrap.
    localparam logic [X_WIDTH:0]      LP_FB_W   = (X_WIDTH+1)'(FB_WIDTH);
    localparam logic [Y_WIDTH:0]      LP_FB_H   = (Y_WIDTH+1)'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LP_STRIDE = ADDR_WIDTH'(FB_WIDTH);

    logic [1:0]            r_state;
    logic [X_WIDTH-1:0]    r_x0;
    logic [Y_WIDTH-1:0]    r_y0;
    logic [X_WIDTH-1:0]    r_w;
    logic [Y_WIDTH-1:0]    r_h;
    logic [X_WIDTH-1:0]    r_col;
    logic [Y_WIDTH-1:0]    r_row;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic                  r_done;
    logic                  r_err;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic [X_WIDTH:0]      w_x_end;
    logic [Y_WIDTH:0]      w_y_end;
    logic                  w_reject;
    logic [ADDR_WIDTH-1:0] w_base0;
    logic                  w_in_write;
    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;

    assign w_x_end    = {1'b0, r_x0} + {1'b0, r_w};
    assign w_y_end    = {1'b0, r_y0} + {1'b0, r_h};
    assign w_reject   = (r_w == '0) || (r_h == '0) || (w_x_end > LP_FB_W) || (w_y_end > LP_FB_H);

    assign w_in_write = (r_state == S_WRITE);
    assign w_accept   = s_valid && w_in_write;
    assign w_col_last = (r_col == r_w - X_WIDTH'(1));
    assign w_row_last = (r_row == r_h - Y_WIDTH'(1));

    // First-row base address y0*FB_WIDTH + x0, built as shifts and adds over the set bits of the stride.
    always_comb begin
        // NOTE: a value is assigned before the loop, so every path drives it and no latch is inferred.
        w_base0 = ADDR_WIDTH'(r_x0);
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (LP_STRIDE[i]) begin
                w_base0 = w_base0 + (ADDR_WIDTH'(r_y0) << i);
            end
        end
    end

    // Command FSM, raster counters and the registered RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so every read sees the value from before this edge.
        if (rst) begin
            r_state    <= S_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_w     <= w;
                        r_h     <= h;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_reject) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_col      <= '0;
                        r_row      <= '0;
                        r_row_base <= w_base0;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_row_base + ADDR_WIDTH'(r_col);
                        r_wr_data <= s_data;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_row      <= r_row + Y_WIDTH'(1);
                                r_row_base <= r_row_base + LP_STRIDE;
                            end
                        end else begin
                            r_col <= r_col + X_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign s_ready = w_in_write;
    assign done    = r_done;
    assign err     = r_err;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
